frogg_lane_ctrl: RTL
====================

Name: frogg_lane_ctrl

Overview:
Reader-side counterpart of the frog controller. It consumes the frog's pixel position, moves one car per traffic lane, and draws the cars from the VGA column/row counts. It also detects frog/car collisions and the frog reaching the top row, and runs the game-state FSM. The top level uses o_Game_State to reset the frog and to gate scoring and display.

Parameters:
c_GAME_WIDTH, 640, playfield width in pixels
c_GAME_HEIGHT, 480, playfield height in pixels
c_TILE, 32, tile size in pixels; frog size and lane height
c_NUM_LANES, 4, number of traffic lanes, 1..8
c_LANE0_ROW, 3, tile row of lane 0; lane i occupies tile row c_LANE0_ROW+i
c_CAR_WIDTH, 64, car length in pixels, less than c_GAME_WIDTH
c_CAR_SPEED, 1275000, clocks per movement tick
c_HOLD, 25000000, clocks spent in HIT or WIN before leaving

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  reset
i_Col_Count_Div  in  10  current pixel column
i_Row_Count_Div  in  10  current pixel row
i_Frog_X  in  10  frog left edge, pixels
i_Frog_Y  in  10  frog top edge, pixels
i_Game_En  in  1  level; 1 = play
o_Draw_Car  out  1  current pixel belongs to a car
o_Hit  out  1  one-cycle collision pulse
o_Win  out  1  one-cycle top-row pulse
o_Game_State  out  2  00 IDLE, 01 RUN, 10 HIT, 11 WIN
o_Score  out  4  consecutive wins, saturating

Behaviour:
- Interface (decided): one clock, i_Clk; reset i_Rst is synchronous and active-high.
- Reset values:
  - state IDLE, o_Hit=0, o_Win=0, o_Score=0
  - tick counter 0, hold counter 0
  - car i X = (i*c_GAME_WIDTH/c_NUM_LANES), i.e. 0, 160, 320, 480 with defaults
- Reset mid-operation (any state) takes priority over every other event.
- Tick counter:
  - Runs only in RUN; cleared on every entry to RUN.
  - Counts 0..c_CAR_SPEED-1. When the count equals c_CAR_SPEED-1 it wraps to 0 and issues one tick.
  - The first tick occurs c_CAR_SPEED clocks after entering RUN.
- Car motion per tick:
  - step(i) = 2*(i+1) pixels.
  - Even lanes move right: X+step; if the result is >= c_GAME_WIDTH, subtract c_GAME_WIDTH.
  - Odd lanes move left: if X < step, X <= X+c_GAME_WIDTH-step; else X-step.
  - Car positions are frozen, never cleared, in IDLE, HIT and WIN.
- Wrap distance: d(a,b) = a-b if a>=b, else a+c_GAME_WIDTH-b. Use 11-bit intermediates, no truncation before the compare.
- Draw (combinational, zero latency, same timing as frog sprite):
  - o_Draw_Car=1 iff row[9:5] equals some lane row and d(col, X_i) < c_CAR_WIDTH.
  - Cars wrap across the screen edge. Drawing is active in all states.
- Collision (w_Collide, combinational):
  - i_Frog_Y[9:5] equals lane row r, and for that lane's car either d(i_Frog_X, X) < c_CAR_WIDTH or d(X, i_Frog_X) < c_TILE.
- FSM, evaluated at each rising edge:
  - IDLE: if i_Game_En=1, go to RUN.
  - RUN, first match wins:
    - i_Game_En=0 → IDLE.
    - w_Collide → HIT; o_Hit=1 next cycle only; score cleared to 0.
    - i_Frog_Y==0 → WIN; o_Win=1 next cycle only; score+1, saturating at 15.
    - Collision has priority over win in the same cycle.
  - HIT / WIN:
    - Hold counter counts c_HOLD clocks; i_Game_En is ignored during the hold.
    - At the end of the hold go to RUN if i_Game_En=1, else IDLE; counter clears.
- o_Hit/o_Win are registered, exactly one cycle wide; they never re-pulse while in HIT/WIN.

Decomposition:
- Package frogg_pkg:
  - state encodings (IDLE/RUN/HIT/WIN)
  - c_TILE, c_GAME_WIDTH, c_GAME_HEIGHT
  - wrap-distance width (11)
- Sub-module frogg_lane_car, instantiated c_NUM_LANES times via generate. It holds:
  - one car X register and its direction/step parameters
  - tick-enabled wrap update
  - draw-span compare and collision compare outputs
- Top holds the FSM, tick/hold counters, score, and the OR-reductions.

Test Plan (c_CAR_SPEED=3, c_HOLD=10):
1. Reset: assert i_Rst 1 cycle → state 00; car X 0/160/320/480; score 0; col=10,row=96 gives o_Draw_Car=1; col=70,row=96 gives 0.
2. Motion: i_Game_En=1 → state 01 next edge; after 3 RUN clocks lane0 X=2, lane1 X=156, lane2 X=326, lane3 X=472.
3. Wrap: force lane0 X=638, tick → X=0; lane1 X=2, tick → X=638; col=5,row=128 with lane1 X=630 → o_Draw_Car=1.
4. Collision: frog (0,96), car0 X=0, score 3 → next edge state 10, o_Hit high exactly 1 cycle, score 0; after 10 clocks → 01.
5. Win/saturation: frog Y=0 in RUN → o_Win 1 cycle, score+1, state 11; repeat 16 times → score 15.
6. Abort: i_Game_En=0 in RUN → IDLE, car X unchanged over 20 clocks; i_Rst during HIT hold → state 00, score 0, o_Hit 0.

Source files
------------

// File: rtl/frogg_pkg.sv
// Shared constants, game-state encoding and the wrap-distance helper for the
// frogger lane/car controller.
package frogg_pkg;

  localparam int unsigned c_TILE        = 32;
  localparam int unsigned c_GAME_WIDTH  = 640;
  localparam int unsigned c_GAME_HEIGHT = 480;

  // Width of wrap-distance intermediates: holds col + width without overflow.
  localparam int unsigned c_DIST_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10,
    ST_WIN  = 2'b11
  } game_state_e;

  // Distance from b forward to a on a circular axis of length span.
  function automatic logic [c_DIST_W-1:0] wrap_dist(
    input logic [c_DIST_W-1:0] a,
    input logic [c_DIST_W-1:0] b,
    input logic [c_DIST_W-1:0] span
  );
    if (a >= b) return a - b;
    else        return a + span - b;
  endfunction

endpackage

// File: rtl/frogg_lane_car.sv
// One traffic lane: a single car X register moving on each tick, plus the
// draw-span and frog-overlap compares for that lane.
module frogg_lane_car
  import frogg_pkg::*;
#(
  parameter int unsigned c_LANE      = 0,
  parameter int unsigned c_NUM_LANES = 4,
  parameter int unsigned c_LANE0_ROW = 3,
  parameter int unsigned c_CAR_WIDTH = 64
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Tick,
  input  logic [9:0] i_Col,
  input  logic [4:0] i_Row_Tile,
  input  logic [9:0] i_Frog_X,
  input  logic [4:0] i_Frog_Row,
  output logic       o_Draw,
  output logic       o_Collide
);

  localparam logic [c_DIST_W-1:0] c_W      = c_DIST_W'(c_GAME_WIDTH);
  localparam logic [c_DIST_W-1:0] c_STEP   = c_DIST_W'(2 * (c_LANE + 1));
  localparam logic [c_DIST_W-1:0] c_CW     = c_DIST_W'(c_CAR_WIDTH);
  localparam logic [c_DIST_W-1:0] c_TW     = c_DIST_W'(c_TILE);
  localparam logic [9:0]          c_X_RST  = 10'(c_LANE * c_GAME_WIDTH / c_NUM_LANES);
  localparam logic [4:0]          c_ROW    = 5'(c_LANE0_ROW + c_LANE);
  localparam bit                  c_RIGHT  = ((c_LANE % 2) == 0);

  logic [9:0]          car_x_q, car_x_d;
  logic [c_DIST_W-1:0] x_ext, sum_right;
  logic [c_DIST_W-1:0] d_col, d_frog_car, d_car_frog;

  // Next car position: even lanes move right, odd lanes left, wrapping at the edge.
  always_comb begin
    car_x_d   = car_x_q;
    x_ext     = {1'b0, car_x_q};
    sum_right = x_ext + c_STEP;
    if (i_Tick) begin
      if (c_RIGHT) begin
        if (sum_right >= c_W) car_x_d = 10'(sum_right - c_W);
        else                  car_x_d = 10'(sum_right);
      end else begin
        if (x_ext < c_STEP)   car_x_d = 10'(x_ext + c_W - c_STEP);
        else                  car_x_d = 10'(x_ext - c_STEP);
      end
    end
  end

  // Car position register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) car_x_q <= c_X_RST;
    else       car_x_q <= car_x_d;
  end

  // Span compares; distances are taken around the screen so cars wrap.
  always_comb begin
    d_col      = wrap_dist({1'b0, i_Col},    {1'b0, car_x_q}, c_W);
    d_frog_car = wrap_dist({1'b0, i_Frog_X}, {1'b0, car_x_q}, c_W);
    d_car_frog = wrap_dist({1'b0, car_x_q},  {1'b0, i_Frog_X}, c_W);
    o_Draw     = (i_Row_Tile == c_ROW) && (d_col < c_CW);
    o_Collide  = (i_Frog_Row == c_ROW) && ((d_frog_car < c_CW) || (d_car_frog < c_TW));
  end

endmodule

// File: rtl/frogg_lane_ctrl.sv
// Frogger lane controller: game-state FSM, car tick and hold timers, score,
// and the per-lane car instances with their draw/collision reductions.
module frogg_lane_ctrl
  import frogg_pkg::*;
#(
  parameter int unsigned c_NUM_LANES = 4,
  parameter int unsigned c_LANE0_ROW = 3,
  parameter int unsigned c_CAR_WIDTH = 64,
  parameter int unsigned c_CAR_SPEED = 1275000,
  parameter int unsigned c_HOLD      = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [9:0] i_Col_Count_Div,
  input  logic [9:0] i_Row_Count_Div,
  input  logic [9:0] i_Frog_X,
  input  logic [9:0] i_Frog_Y,
  input  logic       i_Game_En,
  output logic       o_Draw_Car,
  output logic       o_Hit,
  output logic       o_Win,
  output logic [1:0] o_Game_State,
  output logic [3:0] o_Score
);

  localparam int unsigned c_TICK_W = $clog2(c_CAR_SPEED + 1);
  localparam int unsigned c_HOLD_W = $clog2(c_HOLD + 1);
  localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(c_CAR_SPEED - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(c_HOLD - 1);

  game_state_e         state_q, state_d;
  logic [c_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [c_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]          score_q, score_d;
  logic                hit_q, hit_d;
  logic                win_q, win_d;
  logic                tick;
  logic                collide;
  logic [c_NUM_LANES-1:0] draw_lane, collide_lane;
  logic                unused_row_lsbs;

  assign unused_row_lsbs = ^i_Row_Count_Div[4:0];

  for (genvar gi = 0; gi < c_NUM_LANES; gi++) begin : g_lane
    frogg_lane_car #(
      .c_LANE      (gi),
      .c_NUM_LANES (c_NUM_LANES),
      .c_LANE0_ROW (c_LANE0_ROW),
      .c_CAR_WIDTH (c_CAR_WIDTH)
    ) u_car (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Tick     (tick),
      .i_Col      (i_Col_Count_Div),
      .i_Row_Tile (i_Row_Count_Div[9:5]),
      .i_Frog_X   (i_Frog_X),
      .i_Frog_Row (i_Frog_Y[9:5]),
      .o_Draw     (draw_lane[gi]),
      .o_Collide  (collide_lane[gi])
    );
  end

  assign tick       = (state_q == ST_RUN) && (tick_cnt_q == c_TICK_MAX);
  assign collide    = |collide_lane;
  assign o_Draw_Car = |draw_lane;

  // Next-state logic; the tick counter idles at zero outside RUN so every entry starts fresh.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    hit_d      = 1'b0;
    win_d      = 1'b0;
    hold_cnt_d = '0;
    tick_cnt_d = '0;
    if (state_q == ST_RUN) tick_cnt_d = tick ? '0 : tick_cnt_q + c_TICK_W'(1);
    case (state_q)
      ST_IDLE: if (i_Game_En) state_d = ST_RUN;
      ST_RUN: begin
        if (!i_Game_En) begin
          state_d = ST_IDLE;
        end else if (collide) begin
          state_d = ST_HIT;
          hit_d   = 1'b1;
          score_d = '0;
        end else if (i_Frog_Y == '0) begin
          state_d = ST_WIN;
          win_d   = 1'b1;
          if (score_q != '1) score_d = score_q + 4'd1;
        end
      end
      ST_HIT, ST_WIN: begin
        if (hold_cnt_q == c_HOLD_MAX) state_d = i_Game_En ? ST_RUN : ST_IDLE;
        else                          hold_cnt_d = hold_cnt_q + c_HOLD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, counters, score and registered pulses.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      score_q    <= '0;
      hit_q      <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      win_q      <= win_d;
    end
  end

  assign o_Hit        = hit_q;
  assign o_Win        = win_q;
  assign o_Game_State = state_q;
  assign o_Score      = score_q;

endmodule
